// File: rtl/pio_ramp_sequencer.sv
// pio_ramp_sequencer
//
// Avalon-MM configured setpoint ramp controller. Firmware programs a target
// code, a maximum step size and a step interval. The block walks out_port from
// its present value toward the target. Each move is no larger than the
// programmed step, and moves are separated by the programmed number of clk
// cycles.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   address     register word address
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   readdata    combinational read of the addressed register (0 if unmapped)
//   out_port    current setpoint code
//   busy        ramp in progress
//   irq         level interrupt = STATUS.done & CTRL.irq_en
//
// Register map (word addresses):
//   0 CTRL      bit0 enable, bit1 irq_en, bit2 abort (write-1, reads 0)
//   1 TARGET    ramp target; a write arms a ramp
//   2 STEP      maximum increment per step (0 behaves as 1)
//   3 INTERVAL  clk cycles per step (0 behaves as 1)
//   4 CURRENT   reads out_port; a write loads out_port only while idle
//   5 STATUS    bit0 busy (RO), bit1 done (sticky, write-1-to-clear)

module pio_ramp_sequencer #(
  parameter logic [31:0] RESET_VALUE      = 32'hFFFF_FFFF,
  parameter logic [31:0] DEFAULT_STEP     = 32'd1,
  parameter logic [31:0] DEFAULT_INTERVAL = 32'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] out_port,
  output logic        busy,
  output logic        irq
);

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_TARGET   = 3'd1;
  localparam logic [2:0] ADDR_STEP     = 3'd2;
  localparam logic [2:0] ADDR_INTERVAL = 3'd3;
  localparam logic [2:0] ADDR_CURRENT  = 3'd4;
  localparam logic [2:0] ADDR_STATUS   = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Zero-valued STEP/INTERVAL are treated as 1 so a ramp always makes progress.
  function automatic logic [31:0] at_least_one(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  function automatic logic [31:0] abs_diff(input logic [31:0] a,
                                           input logic [31:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Returns the next output code. A final step lands exactly on the target.
  // Otherwise the code moves by stp toward the target. The output cannot wrap,
  // because the code moves by stp only when the distance exceeds stp.
  function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                              input logic [31:0] tgt,
                                              input logic [31:0] stp);
    logic [31:0] d;
    d = abs_diff(tgt, cur);
    if (d <= stp)
      return tgt;
    else if (tgt > cur)
      return cur + stp;
    else
      return cur - stp;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] out_q, out_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] step_q, step_d;
  logic [31:0] intv_q, intv_d;
  logic [31:0] cnt_q, cnt_d;
  logic        en_q, en_d;
  logic        irqen_q, irqen_d;
  logic        done_q, done_d;

  logic        wr;
  logic        wr_ctrl, wr_tgt, wr_step, wr_intv, wr_cur, wr_stat;
  logic        abort;
  logic [31:0] step_eff;
  logic        last_step;

  assign wr      = chipselect & ~write_n;
  assign wr_ctrl = wr && (address == ADDR_CTRL);
  assign wr_tgt  = wr && (address == ADDR_TARGET);
  assign wr_step = wr && (address == ADDR_STEP);
  assign wr_intv = wr && (address == ADDR_INTERVAL);
  assign wr_cur  = wr && (address == ADDR_CURRENT);
  assign wr_stat = wr && (address == ADDR_STATUS);
  assign abort   = wr_ctrl && writedata[2];

  assign step_eff  = at_least_one(step_q);
  assign last_step = (abs_diff(tgt_q, out_q) <= step_eff);

  // Next-state and next-register logic
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    intv_d  = intv_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    irqen_d = irqen_q;
    done_d  = done_q;

    if (wr_ctrl) begin
      en_d    = writedata[0];
      irqen_d = writedata[1];
    end
    if (wr_tgt)  tgt_d  = writedata;
    if (wr_step) step_d = writedata;
    if (wr_intv) intv_d = writedata;
    if (wr_stat && writedata[1]) done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_cur) out_d = writedata;
        if (wr_tgt) begin
          if (writedata == out_q) begin
            done_d = 1'b1;
          end else if (en_q) begin
            state_d = RUN;
            cnt_d   = at_least_one(intv_q);
          end
        end
        // A target stored while disabled starts when enable goes 0 -> 1.
        if (wr_ctrl && writedata[0] && !writedata[2] && !en_q &&
            (tgt_q != out_q)) begin
          state_d = RUN;
          cnt_d   = at_least_one(intv_q);
        end
      end
      RUN: begin
        if (abort) begin
          // Abort beats a step that falls due on the same edge.
          state_d = IDLE;
        end else if (en_q) begin
          if (cnt_q <= 32'd1) begin
            out_d = step_toward(out_q, tgt_q, step_eff);
            if (last_step) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              cnt_d = at_least_one(intv_q);
            end
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and register update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= RESET_VALUE;
      tgt_q   <= RESET_VALUE;
      step_q  <= DEFAULT_STEP;
      intv_q  <= DEFAULT_INTERVAL;
      cnt_q   <= 32'd0;
      en_q    <= 1'b0;
      irqen_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      intv_q  <= intv_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      irqen_q <= irqen_d;
      done_q  <= done_d;
    end
  end

  assign out_port = out_q;
  assign busy     = (state_q == RUN);
  assign irq      = done_q & irqen_q;

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL:     readdata = {30'd0, irqen_q, en_q};
      ADDR_TARGET:   readdata = tgt_q;
      ADDR_STEP:     readdata = step_q;
      ADDR_INTERVAL: readdata = intv_q;
      ADDR_CURRENT:  readdata = out_q;
      ADDR_STATUS:   readdata = {30'd0, done_q, busy};
      default:       readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_pio_ramp_sequencer.sv
// Directed testbench for pio_ramp_sequencer. Expected values are hand-computed
// from the register and timing description of the block.
module tb_pio_ramp_sequencer;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_port;
  logic        busy;
  logic        irq;

  int n_checks;
  int n_errors;
  logic [31:0] rd;

  pio_ramp_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .busy       (busy),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (got running, need finished)");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write at the next posedge (edge E); returns 1 ns after E.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("rst_out", out_port, 32'hFFFF_FFFF);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    bus_read(3'd2, rd); check_val("rst_step", rd, 32'd1);
    bus_read(3'd3, rd); check_val("rst_intv", rd, 32'd1000);

    // Up-ramp 100 -> 125, step 10, interval 4; start via CTRL enable
    bus_write(3'd4, 32'd100);
    bus_write(3'd2, 32'd10);
    bus_write(3'd3, 32'd4);
    bus_write(3'd1, 32'd125);
    check_val("up_armed_idle", {31'd0, busy}, 32'd0);
    bus_write(3'd0, 32'd3);                      // edge E
    check_val("up_busy", {31'd0, busy}, 32'd1);
    wait_edges(3); check_val("up_e3", out_port, 32'd100);
    wait_edges(1); check_val("up_e4", out_port, 32'd110);
    wait_edges(4); check_val("up_e8", out_port, 32'd120);
    check_val("up_irq_lo", {31'd0, irq}, 32'd0);
    wait_edges(4); check_val("up_e12", out_port, 32'd125);
    check_val("up_busy_end", {31'd0, busy}, 32'd0);
    check_val("up_irq", {31'd0, irq}, 32'd1);
    bus_read(3'd5, rd); check_val("up_status", rd, 32'd2);
    bus_write(3'd5, 32'd2);
    check_val("up_irq_clr", {31'd0, irq}, 32'd0);

    // Down-ramp with zero STEP/INTERVAL
    bus_write(3'd4, 32'd50);
    bus_write(3'd2, 32'd0);
    bus_write(3'd3, 32'd0);
    bus_write(3'd1, 32'd47);                     // edge E
    check_val("dn_busy", {31'd0, busy}, 32'd1);
    wait_edges(1); check_val("dn_e1", out_port, 32'd49);
    wait_edges(1); check_val("dn_e2", out_port, 32'd48);
    check_val("dn_busy2", {31'd0, busy}, 32'd1);
    wait_edges(1); check_val("dn_e3", out_port, 32'd47);
    check_val("dn_busy_end", {31'd0, busy}, 32'd0);
    bus_write(3'd5, 32'd2);

    // Retarget and pause
    bus_write(3'd4, 32'd0);
    bus_write(3'd2, 32'd100);
    bus_write(3'd3, 32'd8);
    bus_write(3'd1, 32'd1000);                   // edge E
    wait_edges(24); check_val("rt_e24", out_port, 32'd300);
    bus_write(3'd1, 32'd150);                    // E+25
    wait_edges(6); check_val("rt_e31", out_port, 32'd300);
    wait_edges(1); check_val("rt_e32", out_port, 32'd200);
    bus_write(3'd0, 32'd2);                      // E+33: enable off
    wait_edges(4); check_val("rt_pause_hold", out_port, 32'd200);
    bus_write(3'd0, 32'd3);                      // E+38: enable on
    wait_edges(6); check_val("rt_e44", out_port, 32'd200);
    check_val("rt_busy44", {31'd0, busy}, 32'd1);
    wait_edges(1); check_val("rt_e45", out_port, 32'd150);
    check_val("rt_busy_end", {31'd0, busy}, 32'd0);
    check_val("rt_irq", {31'd0, irq}, 32'd1);
    bus_write(3'd5, 32'd2);

    // Abort mid-ramp at 400
    bus_write(3'd4, 32'd0);
    bus_write(3'd1, 32'd1000);                   // edge E
    wait_edges(32); check_val("ab_e32", out_port, 32'd400);
    bus_write(3'd0, 32'd7);
    check_val("ab_busy", {31'd0, busy}, 32'd0);
    check_val("ab_out", out_port, 32'd400);
    bus_read(3'd5, rd); check_val("ab_status", rd, 32'd0);
    bus_read(3'd0, rd); check_val("ab_ctrl", rd, 32'd3);
    wait_edges(10); check_val("ab_hold", out_port, 32'd400);
    bus_write(3'd4, 32'd7);
    check_val("ab_cur", out_port, 32'd7);
    check_val("ab_idle", {31'd0, busy}, 32'd0);

    // TARGET equal to out_port
    bus_write(3'd1, 32'd7);
    check_val("eq_busy", {31'd0, busy}, 32'd0);
    bus_read(3'd5, rd); check_val("eq_status", rd, 32'd2);
    check_val("eq_irq", {31'd0, irq}, 32'd1);
    bus_write(3'd5, 32'd2);

    // Large step near the top of the range: no wrap
    bus_write(3'd4, 32'hFFFF_FFF0);
    bus_write(3'd2, 32'h8000_0000);
    bus_write(3'd3, 32'd2);
    bus_write(3'd1, 32'hFFFF_FFFF);              // edge E
    wait_edges(1); check_val("wr_e1", out_port, 32'hFFFF_FFF0);
    wait_edges(1); check_val("wr_e2", out_port, 32'hFFFF_FFFF);
    check_val("wr_busy", {31'd0, busy}, 32'd0);
    bus_write(3'd5, 32'd2);

    // Reset mid-ramp
    bus_write(3'd4, 32'd0);
    bus_write(3'd2, 32'd1);
    bus_write(3'd3, 32'd1);
    bus_write(3'd1, 32'd100);                    // edge E
    wait_edges(3); check_val("mr_e3", out_port, 32'd3);
    reset = 1'b1;
    wait_edges(1);
    reset = 1'b0;
    check_val("mr_out", out_port, 32'hFFFF_FFFF);
    check_val("mr_busy", {31'd0, busy}, 32'd0);
    check_val("mr_irq", {31'd0, irq}, 32'd0);
    bus_read(3'd1, rd); check_val("mr_target", rd, 32'hFFFF_FFFF);
    bus_read(3'd2, rd); check_val("mr_step", rd, 32'd1);
    wait_edges(1);
    bus_read(3'd3, rd); check_val("mr_intv", rd, 32'd1000);
    bus_read(3'd0, rd); check_val("mr_ctrl", rd, 32'd0);
    bus_read(3'd6, rd); check_val("unmapped", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
